// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int unsigned WORD_W = 16;
   localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;
   localparam logic [WORD_W-1:0] PC_INC = 16'd2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc_plus_2;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch stage and memory.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ack;
   logic [WORD_W-1:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_buf.sv
// Prefetch FIFO of {instr, pc_plus_2}; pointers wrap modulo BUF_DEPTH, flush beats push.
module fetch_buf
   import fetch_unit_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wr_entry,
   output fetch_entry_t     head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

   fetch_entry_t     mem [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(BUF_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~flush & ~empty;
   assign do_push = push & ~flush & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= inc_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= inc_ptr(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, runs the imem req/ack handshake and feeds IF/ID from a prefetch buffer.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int unsigned BUF_DEPTH = 2,
   parameter logic [15:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_unit_if.master        imem,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [WORD_W-1:0]   branch_target,
   output logic [WORD_W-1:0]   instruction,
   output logic [WORD_W-1:0]   pc_plus_2,
   output logic                ifid_en
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] fetch_pc;
   logic [WORD_W-1:0] fetch_pc_nxt;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_addr_nxt;
   logic [WORD_W-1:0] target;
   logic [WORD_W-1:0] addr;
   logic              req;
   logic              push;
   logic              pop;
   logic              room_after;
   logic              buf_full;
   logic              buf_empty;
   logic [CNT_W-1:0]  buf_count;
   fetch_entry_t      head;
   fetch_entry_t      wr_entry;

   assign target   = branch_target & 16'hFFFE;
   assign addr     = (state == IDLE) ? fetch_pc : req_addr;
   assign wr_entry = '{instr: imem.imem_rdata, pc_plus_2: addr + PC_INC};
   assign pop      = ~stall & ~buf_empty & ~branch_taken;
   // Room for a back-to-back request once this cycle's push/pop have landed.
   assign room_after = (buf_count - CNT_W'(pop)) < CNT_W'(BUF_DEPTH - 1);

   assign imem.imem_req  = rst_n & req;
   assign imem.imem_addr = addr;

   fetch_buf #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (branch_taken),
      .wr_entry (wr_entry),
      .head     (head),
      .full     (buf_full),
      .empty    (buf_empty),
      .count    (buf_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         req_addr <= req_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      req_addr_nxt = req_addr;
      req          = 1'b0;
      push         = 1'b0;
      case (state)
         IDLE: begin
            if (branch_taken) begin
               fetch_pc_nxt = target;
            end else if (!buf_full) begin
               req = 1'b1;
               if (imem.imem_ack) begin
                  push         = 1'b1;
                  fetch_pc_nxt = fetch_pc + PC_INC;
               end else begin
                  state_nxt    = WAIT;
                  req_addr_nxt = fetch_pc;
               end
            end
         end
         WAIT: begin
            req = 1'b1;
            if (branch_taken) begin
               fetch_pc_nxt = target;
               state_nxt    = imem.imem_ack ? IDLE : DISCARD;
            end else if (imem.imem_ack) begin
               push         = 1'b1;
               fetch_pc_nxt = fetch_pc + PC_INC;
               if (room_after) req_addr_nxt = fetch_pc + PC_INC;
               else            state_nxt    = IDLE;
            end
         end
         DISCARD: begin
            req = 1'b1;
            if (branch_taken)   fetch_pc_nxt = target;
            if (imem.imem_ack)  state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A redirect squashes IF/ID with a forced bubble regardless of stall.
   always_comb begin
      instruction = NOP_INSTR;
      pc_plus_2   = fetch_pc + PC_INC;
      ifid_en     = rst_n & (branch_taken | ~stall);
      if (!branch_taken && !buf_empty) begin
         instruction = head.instr;
         pc_plus_2   = head.pc_plus_2;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a configurable-latency memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic [15:0] tgt = 16'h0000;
   logic        hold_ack = 1'b0;
   int          lat = 0;
   int          wcnt = 0;
   logic        zero = 1'b0;
   logic [15:0] zero16 = 16'h0000;

   logic [15:0] instr1, pc2_1, instr2, pc2_2;
   logic        en1, en2;
   logic [49:0] got1, got2;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [49:0] M_ALL  = '1;
   localparam logic [49:0] M_NOPC = {1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};

   fetch_unit_if mif ();
   fetch_unit_if mif2 ();

   assign mif.imem_ack    = mif.imem_req & ~hold_ack & (wcnt >= lat);
   assign mif.imem_rdata  = mif.imem_addr ^ 16'hA5A5;
   assign mif2.imem_ack   = mif2.imem_req;
   assign mif2.imem_rdata = mif2.imem_addr ^ 16'hA5A5;

   fetch_unit #(.RESET_PC(16'h0000), .BUF_DEPTH(2), .NOP_INSTR(16'h0000)) u_dut (
      .clk (clk), .rst_n (rst_n), .imem (mif.master), .stall (stall),
      .branch_taken (branch), .branch_target (tgt),
      .instruction (instr1), .pc_plus_2 (pc2_1), .ifid_en (en1)
   );

   fetch_unit #(.RESET_PC(16'hFFFC), .BUF_DEPTH(2), .NOP_INSTR(16'h0000)) u_dut2 (
      .clk (clk), .rst_n (rst_n), .imem (mif2.master), .stall (zero),
      .branch_taken (zero), .branch_target (zero16),
      .instruction (instr2), .pc_plus_2 (pc2_2), .ifid_en (en2)
   );

   assign got1 = {mif.imem_req, mif.imem_addr, instr1, pc2_1, en1};
   assign got2 = {mif2.imem_req, mif2.imem_addr, instr2, pc2_2, en2};

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt <= 0;
      else if (mif.imem_req && !mif.imem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   typedef struct {
      logic        stall;
      logic        br;
      logic [15:0] tgt;
      logic        req;
      logic [15:0] addr;
      logic [15:0] instr;
      logic [15:0] pc2;
      logic        en;
      logic        pc_dc;
   } vec_t;

   vec_t vt [14];

   logic [15:0] a_addr  [9] = '{16'h0, 16'h0, 16'h0, 16'h2, 16'h2, 16'h2, 16'h4, 16'h4, 16'h4};
   logic [15:0] a_instr [9] = '{16'h0, 16'h0, 16'h0, 16'hA5A5, 16'h0, 16'h0, 16'hA5A7, 16'h0, 16'h0};
   logic [15:0] a_pc2   [9] = '{16'h2, 16'h2, 16'h2, 16'h2, 16'h4, 16'h4, 16'h4, 16'h6, 16'h6};

   task automatic check(input string nm, input logic [49:0] got, input logic [49:0] exp,
                        input logic [49:0] mask);
      n_vec++;
      if (((got ^ exp) & mask) !== '0) begin
         n_err++;
         $display("FAIL %s: got req=%b addr=%h instr=%h pc2=%h en=%b, want req=%b addr=%h instr=%h pc2=%h en=%b",
                  nm, got[49], got[48:33], got[32:17], got[16:1], got[0],
                  exp[49], exp[48:33], exp[32:17], exp[16:1], exp[0]);
      end
   endtask

   task automatic drive(input logic s, input logic b, input logic [15:0] t);
      stall  = s;
      branch = b;
      tgt    = t;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; stall = 1'b0; branch = 1'b0; hold_ack = 1'b0; lat = 0;
      #1;
      check("reset_dut", got1, {1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b0}, M_ALL);
      check("reset_dut2", got2, {1'b0, 16'hFFFC, 16'h0000, 16'hFFFE, 1'b0}, M_ALL);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      //          stall br    tgt       req   addr      instr     pc2       en    pc_dc
      vt[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'hA5A5, 16'h0002, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'hA5A7, 16'h0004, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A1, 16'h0006, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'hA5A1, 16'h0006, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'hA5A1, 16'h0006, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'hA5A1, 16'h0006, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'hA5A1, 16'h0006, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'hA5A1, 16'h0006, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'hA5A3, 16'h0008, 1'b1, 1'b0};
      vt[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'hA5AD, 16'h000A, 1'b1, 1'b0};
      vt[11] = '{1'b0, 1'b1, 16'h0041, 1'b0, 16'h000C, 16'h0000, 16'h0000, 1'b1, 1'b1};
      vt[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0000, 16'h0042, 1'b1, 1'b0};
      vt[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 16'hA5E5, 16'h0042, 1'b1, 1'b0};

      // Zero-wait streaming, 5-cycle stall, drain, redirect.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(vt[i].stall, vt[i].br, vt[i].tgt);
         check($sformatf("vec%0d", i), got1,
               {vt[i].req, vt[i].addr, vt[i].instr, vt[i].pc2, vt[i].en},
               vt[i].pc_dc ? M_NOPC : M_ALL);
         @(negedge clk);
      end

      // Three-cycle ack latency: bubbles while the buffer is empty.
      do_reset();
      lat = 2;
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b0, 16'h0000);
         check($sformatf("lat3_c%0d", i), got1, {1'b1, a_addr[i], a_instr[i], a_pc2[i], 1'b1}, M_ALL);
         @(negedge clk);
      end

      // Redirect while the request to 0006 is unacked.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 16'h0000);
         @(negedge clk);
      end
      hold_ack = 1'b1;
      drive(1'b1, 1'b0, 16'h0000);
      check("br_pending", got1, {1'b1, 16'h0006, 16'hA5A1, 16'h0006, 1'b0}, M_ALL);
      @(negedge clk);
      drive(1'b1, 1'b1, 16'h0040);
      check("br_squash", got1, {1'b1, 16'h0006, 16'h0000, 16'h0000, 1'b1}, M_NOPC);
      @(negedge clk);
      hold_ack = 1'b0;
      drive(1'b0, 1'b0, 16'h0000);
      check("br_discard", got1, {1'b1, 16'h0006, 16'h0000, 16'h0042, 1'b1}, M_ALL);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000);
      check("br_target_req", got1, {1'b1, 16'h0040, 16'h0000, 16'h0042, 1'b1}, M_ALL);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000);
      check("br_target_out", got1, {1'b1, 16'h0042, 16'hA5E5, 16'h0042, 1'b1}, M_ALL);
      @(negedge clk);

      // RESET_PC near the top of the address space wraps modulo 2^16.
      do_reset();
      drive(1'b0, 1'b0, 16'h0000);
      check("wrap_c0", got2, {1'b1, 16'hFFFC, 16'h0000, 16'hFFFE, 1'b1}, M_ALL);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000);
      check("wrap_c1", got2, {1'b1, 16'hFFFE, 16'h5A59, 16'hFFFE, 1'b1}, M_ALL);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000);
      check("wrap_c2", got2, {1'b1, 16'h0000, 16'h5A5B, 16'h0000, 1'b1}, M_ALL);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000);
      check("wrap_c3", got2, {1'b1, 16'h0002, 16'hA5A5, 16'h0002, 1'b1}, M_ALL);
      @(negedge clk);

      // Asynchronous reset in the middle of a WAIT.
      do_reset();
      hold_ack = 1'b1;
      drive(1'b0, 1'b0, 16'h0000);
      check("mid_c0", got1, {1'b1, 16'h0000, 16'h0000, 16'h0002, 1'b1}, M_ALL);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000);
      check("mid_wait", got1, {1'b1, 16'h0000, 16'h0000, 16'h0002, 1'b1}, M_ALL);
      #2 rst_n = 1'b0;
      #1;
      check("mid_async_rst", got1, {1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b0}, M_ALL);
      @(negedge clk);
      hold_ack = 1'b0;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 16'h0000);
      check("mid_restart", got1, {1'b1, 16'h0000, 16'h0000, 16'h0002, 1'b1}, M_ALL);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000);
      check("mid_first", got1, {1'b1, 16'h0002, 16'hA5A5, 16'h0002, 1'b1}, M_ALL);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
